// File: rtl/mdu_iter_if.sv
// ============================================================================
// Module      : mdu_iter_if
// Description : Request/result handshake bundle for the iterative MUL/DIV unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mdu_iter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic                  in_valid;
    logic                  in_ready;
    logic [2:0]            op;
    logic [DATA_WIDTH-1:0] src1;
    logic [DATA_WIDTH-1:0] src2;
    logic [ADDR_WIDTH-1:0] rd;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic [ADDR_WIDTH-1:0] out_rd;

    modport master (
        output in_valid, op, src1, src2, rd, out_ready,
        input  in_ready, out_valid, out_data, out_rd
    );

    modport slave (
        input  in_valid, op, src1, src2, rd, out_ready,
        output in_ready, out_valid, out_data, out_rd
    );
endinterface

`default_nettype wire

// File: rtl/mdu_iter.sv
// ============================================================================
// Module      : mdu_iter
// Description : Iterative RV32M multiply (shift-add) / divide (restoring) unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mdu_iter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  wire logic   clk,
    input  wire logic   rst,
    input  wire logic   flush,
    mdu_iter_if.slave   bus
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);
    localparam logic [W-1:0]  MOST_NEG = {1'b1, {(W-1){1'b0}}};

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_REM    = 3'b110;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [2:0]            op_q, op_d;
    logic [ADDR_WIDTH-1:0] rd_q, rd_d;
    logic [W-1:0]          a_q, a_d;
    logic [2*W-1:0]        acc_q, acc_d;
    logic                  neg_q, neg_d;
    logic [W-1:0]          data_q, data_d;

    // Request decode: both units work on magnitudes and fix the sign at the end.
    logic         w_s1, w_s2, w_is_div, w_div0, w_ovf;
    logic [W-1:0] w_mag1, w_mag2, w_spec;

    always_comb begin
        w_is_div = bus.op[2];
        w_s1     = bus.src1[W-1] & ((bus.op == OP_MULH) | (bus.op == OP_MULHSU) |
                                    (bus.op == OP_DIV)  | (bus.op == OP_REM));
        w_s2     = bus.src2[W-1] & ((bus.op == OP_MULH) | (bus.op == OP_DIV) |
                                    (bus.op == OP_REM));
        w_mag1   = w_s1 ? -bus.src1 : bus.src1;
        w_mag2   = w_s2 ? -bus.src2 : bus.src2;
        w_div0   = w_is_div & (bus.src2 == '0);
        w_ovf    = ((bus.op == OP_DIV) | (bus.op == OP_REM)) &
                   (bus.src1 == MOST_NEG) & (bus.src2 == '1);
        if (w_div0) begin
            w_spec = bus.op[1] ? bus.src1 : '1;
        end else begin
            w_spec = bus.op[1] ? '0 : bus.src1;
        end
    end

    // One iteration: acc holds {hi, multiplier} for multiply, {remainder, quotient} for divide.
    logic [W:0]     w_mul_sum, w_div_shift, w_div_diff;
    logic           w_div_ge;
    logic [2*W-1:0] w_step, w_prod;
    logic [W-1:0]   w_quot, w_rem, w_final;

    always_comb begin
        w_mul_sum   = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, a_q} : '0);
        w_div_shift = acc_q[2*W-1:W-1];
        w_div_diff  = w_div_shift - {1'b0, a_q};
        w_div_ge    = ~w_div_diff[W];
        if (op_q[2]) begin
            w_step = {(w_div_ge ? w_div_diff[W-1:0] : w_div_shift[W-1:0]),
                      acc_q[W-2:0], w_div_ge};
        end else begin
            w_step = {w_mul_sum, acc_q[W-1:1]};
        end
        w_prod = neg_q ? -w_step : w_step;
        w_quot = neg_q ? -w_step[W-1:0] : w_step[W-1:0];
        w_rem  = neg_q ? -w_step[2*W-1:W] : w_step[2*W-1:W];
        if (op_q[2]) begin
            w_final = op_q[1] ? w_rem : w_quot;
        end else begin
            w_final = (op_q[1:0] == 2'b00) ? w_prod[W-1:0] : w_prod[2*W-1:W];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        rd_d    = rd_q;
        a_d     = a_q;
        acc_d   = acc_q;
        neg_d   = neg_q;
        data_d  = data_q;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid && !flush) begin
                    op_d  = bus.op;
                    rd_d  = bus.rd;
                    a_d   = w_is_div ? w_mag2 : w_mag1;
                    acc_d = {{W{1'b0}}, (w_is_div ? w_mag1 : w_mag2)};
                    neg_d = (bus.op == OP_REM) ? w_s1 : (w_s1 ^ w_s2);
                    cnt_d = '0;
                    if (w_div0 || w_ovf) begin
                        data_d  = w_spec;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                acc_d = w_step;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    data_d  = w_final;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (flush) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            rd_q    <= '0;
            a_q     <= '0;
            acc_q   <= '0;
            neg_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            rd_q    <= rd_d;
            a_q     <= a_d;
            acc_q   <= acc_d;
            neg_q   <= neg_d;
            data_q  <= data_d;
        end
    end

    // in_ready is gated by reset so nothing is offered while rst is held low.
    assign bus.in_ready  = rst & (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.out_data  = data_q;
    assign bus.out_rd    = rd_q;

endmodule

`default_nettype wire

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Iterative RV32M multiply/divide unit in the execute stage of the single-issue core.
- Sits directly downstream of the register file: consumes rs1/rs2 read data and produces a writeback value plus destination index for the register-file write port.
- Uses a valid/ready handshake on both sides so the controller can stall while an operation is in progress.

Parameters:
- DATA_WIDTH, 32, operand/result width (XLEN); must be even and >= 8.
- ADDR_WIDTH, 5, destination register index width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- flush  input  1  synchronous kill of the in-flight or pending operation.
- in_valid  input  1  request valid.
- in_ready  output  1  unit can accept a request.
- op  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- src1  input  DATA_WIDTH  rs1 value (dividend / multiplicand).
- src2  input  DATA_WIDTH  rs2 value (divisor / multiplier).
- rd  input  ADDR_WIDTH  destination index, carried through unchanged.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer takes the result.
- out_data  output  DATA_WIDTH  result.
- out_rd  output  ADDR_WIDTH  destination index of the result.

Behaviour:
- Reset (rst=0, async):
  - State goes to IDLE and the counter clears.
  - out_valid=0, in_ready=1 once rst releases, out_data=0, out_rd=0.
  - Any in-flight operation is dropped.
- FSM states: IDLE, CALC, DONE.
  - in_ready=1 only in IDLE. out_valid=1 only in DONE.
- IDLE:
  - Request is accepted on an edge where in_valid=1 and flush=0.
  - On acceptance, latch op, rd, operands and operand signs.
  - If the special-case condition holds, go directly to DONE with the result registered (latency 1).
  - Otherwise go to CALC with counter=0.
- CALC: one step per cycle for DATA_WIDTH cycles.
  - On the step with counter=DATA_WIDTH-1, register the final (sign-corrected) result and go to DONE.
  - out_valid therefore rises exactly DATA_WIDTH cycles after the acceptance edge; 32 cycles by default.
- DONE:
  - out_data and out_rd are held stable while out_ready=0.
  - When out_ready=1, go to IDLE on that edge.
  - There is no same-cycle accept of a new request, so back-to-back throughput is one operation per DATA_WIDTH+2 cycles.
- flush:
  - Any state goes to IDLE on the next edge and out_valid drops.
  - flush takes priority over in_valid and out_ready; the flushed result is never presented.
- Multiply (shift-add):
  - Operands are extended to DATA_WIDTH+1 bits: signed for MULH (both operands) and MULHSU (src1 only), zero-extended otherwise.
  - Accumulate a 2*DATA_WIDTH product.
  - MUL returns the low half; MULH/MULHSU/MULHU return the high half.
  - MUL result is identical for signed and unsigned inputs.
- Divide (restoring):
  - Operates on magnitudes: |src| for DIV/REM, raw value for DIVU/REMU.
  - Quotient sign = sign1 XOR sign2.
  - Remainder sign = sign of dividend.
  - Truncation is toward zero.
- Special cases, 1-cycle path:
  - Divisor == 0: DIV/DIVU return all-ones; REM/REMU return src1.
  - Signed overflow (src1 = most-negative, src2 = -1): DIV returns src1; REM returns 0.
- rd=0 is computed normally and passed through; the register file discards the write.
- Operands are sampled only at acceptance; src/op/rd changes afterwards have no effect.

Test Plan:
- Reset, then MUL src1=7, src2=0xFFFFFFFD, rd=5 -> out_valid exactly 32 cycles after accept; out_data=0xFFFFFFEB, out_rd=5.
- MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULH same operands -> 0x00000000; MULHSU 0xFFFFFFFF,0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIVU 0x1234/0 -> 0xFFFFFFFF with out_valid 1 cycle after accept; REM 0x1234/0 -> 0x1234; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0.
- Hold out_ready=0 for 10 cycles in DONE -> out_data/out_rd stable, in_ready=0; out_ready=1 -> in_ready=1 next cycle; in_valid held high with flush=0 is accepted only in IDLE.
- Pulse flush at CALC counter=10 -> IDLE next cycle, no out_valid.
- Drive rst=0 mid-CALC off-edge -> out_valid=0 and in_ready=0 immediately; in_ready=1 after release; a new MUL 3*4 -> 12.
